// File: rtl/mul_sched_pkg.sv
// Shared definitions for the multiplier-sharing scheduler: FSM state encoding
// and the default datapath width.
package mul_sched_pkg;

   localparam int DEF_W = 16;

   localparam logic [2:0] ST_IDLE = 3'd0;
   localparam logic [2:0] ST_LD_A = 3'd1;
   localparam logic [2:0] ST_LD_B = 3'd2;
   localparam logic [2:0] ST_RUN  = 3'd3;
   localparam logic [2:0] ST_DONE = 3'd4;

   typedef enum logic [2:0] {
      IDLE = ST_IDLE,
      LD_A = ST_LD_A,
      LD_B = ST_LD_B,
      RUN  = ST_RUN,
      DONE = ST_DONE
   } state_t;

endpackage

// File: rtl/mul_share_sched_rr_arbiter.sv
// Combinational round-robin arbiter: picks the first request above ptr
// (wrapping) and returns it one-hot plus as an index.
module rr_arbiter #(
   parameter int NREQ = 4,
   parameter int IDW  = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [IDW-1:0]  ptr,
   output logic [NREQ-1:0] grant,
   output logic [IDW-1:0]  idx,
   output logic            found
);

   int pos;

   // NOTE: every variable gets a default before the search loop, so no path
   // leaves one unassigned and no latch is inferred.
   always_comb begin
      grant = '0;
      idx   = '0;
      found = 1'b0;
      pos   = 0;
      for (int i = 1; i <= NREQ; i++) begin
         pos = (int'(ptr) + i) % NREQ;
         if (!found && req[pos]) begin
            found      = 1'b1;
            grant[pos] = 1'b1;
            idx        = IDW'(pos);
         end
      end
   end

endmodule

// File: rtl/mul_share_sched.sv
// Round-robin scheduler sharing one repeated-addition multiplier datapath.
// Optional MUL_OPSWAP_EN: swap operands so the smaller one sets the iteration count.
module mul_share_sched
   import mul_sched_pkg::*;
#(
   parameter int W    = DEF_W,
   parameter int NREQ = 4,
   parameter int IDW  = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [NREQ-1:0] req_valid,
   input  logic [NREQ*W-1:0] req_a,
   input  logic [NREQ*W-1:0] req_b,
   output logic [NREQ-1:0] req_ack,
   output logic            rsp_valid,
   output logic [IDW-1:0]  rsp_id,
   output logic [W-1:0]    rsp_data,
   output logic            busy,
   input  logic            eqz,
   input  logic [W-1:0]    y_in,
   output logic            LdA,
   output logic            LdB,
   output logic            LdP,
   output logic            clrP,
   output logic            decB,
   output logic [W-1:0]    data_out
);

   state_t          state;
   logic [IDW-1:0]  ptr;
   logic [IDW-1:0]  id;
   logic [W-1:0]    op_b;

   logic [NREQ-1:0] grant;
   logic [IDW-1:0]  gnt_idx;
   logic            any_req;
   logic [W-1:0]    a_g, b_g, sel_a, sel_b;

   rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
      .req   (req_valid),
      .ptr   (ptr),
      .grant (grant),
      .idx   (gnt_idx),
      .found (any_req)
   );

   assign a_g = req_a[int'(gnt_idx)*W +: W];
   assign b_g = req_b[int'(gnt_idx)*W +: W];

`ifdef MUL_OPSWAP_EN
   always_comb begin
      sel_a = a_g;
      sel_b = b_g;
      if (a_g < b_g) begin
         sel_a = b_g;
         sel_b = a_g;
      end
   end
`else
   assign sel_a = a_g;
   assign sel_b = b_g;
`endif

   // Ack is gated by rst_n so it stays low while reset is held, even in IDLE.
   assign req_ack = (state == IDLE && rst_n) ? grant : '0;
   assign busy    = (state != IDLE);
   // The loop decision depends on eqz in the same cycle, so these stay combinational.
   assign LdP     = (state == RUN) && !eqz;
   assign decB    = (state == RUN) && !eqz;

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         ptr       <= IDW'(NREQ-1);
         id        <= '0;
         op_b      <= '0;
         data_out  <= '0;
         LdA       <= 1'b0;
         LdB       <= 1'b0;
         clrP      <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_id    <= '0;
         rsp_data  <= '0;
      end else begin
         data_out  <= '0;
         LdA       <= 1'b0;
         LdB       <= 1'b0;
         clrP      <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_id    <= '0;
         rsp_data  <= '0;
         unique case (state)
            IDLE: begin
               if (any_req) begin
                  op_b     <= sel_b;
                  id       <= gnt_idx;
                  ptr      <= gnt_idx;
                  data_out <= sel_a;
                  LdA      <= 1'b1;
                  state    <= LD_A;
               end
            end
            LD_A: begin
               data_out <= op_b;
               LdB      <= 1'b1;
               clrP     <= 1'b1;
               state    <= LD_B;
            end
            LD_B: state <= RUN;
            RUN: begin
               // y_in is final here: no LdP is issued in the cycle eqz is seen.
               if (eqz) begin
                  rsp_valid <= 1'b1;
                  rsp_data  <= y_in;
                  rsp_id    <= id;
                  state     <= DONE;
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mul_share_sched.sv
// Directed bench for mul_share_sched with a behavioural repeated-addition datapath.
// Honours MUL_OPSWAP_EN when choosing expected operand order and latency.
module tb_mul_share_sched;

   localparam int W    = 16;
   localparam int NREQ = 4;
   localparam int IDW  = 2;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [NREQ-1:0]   req_valid;
   logic [NREQ*W-1:0] req_a, req_b;
   logic [NREQ-1:0]   req_ack;
   logic              rsp_valid;
   logic [IDW-1:0]    rsp_id;
   logic [W-1:0]      rsp_data;
   logic              busy, eqz;
   logic [W-1:0]      y_in;
   logic              LdA, LdB, LdP, clrP, decB;
   logic [W-1:0]      data_out;

   int n_checks = 0;
   int n_errors = 0;
   int viol     = 0;
   int rsp_seen = 0;

   logic [W-1:0] dp_a = '0, dp_b = '0, dp_p = '0;

   mul_share_sched #(.W(W), .NREQ(NREQ), .IDW(IDW)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ack(req_ack),
      .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .busy(busy),
      .eqz(eqz), .y_in(y_in),
      .LdA(LdA), .LdB(LdB), .LdP(LdP), .clrP(clrP), .decB(decB),
      .data_out(data_out)
   );

   always #5 clk = ~clk;

   // Behavioural datapath: A, B, P registers driven by the scheduler's controls.
   always @(posedge clk) begin
      if (LdA) dp_a <= data_out;
      if (LdB) dp_b <= data_out;
      else if (decB) dp_b <= dp_b - 1'b1;
      if (clrP) dp_p <= '0;
      else if (LdP) dp_p <= dp_p + dp_a;
   end
   assign eqz  = (dp_b == '0);
   assign y_in = dp_p;

   // Protocol observer: legal control combinations, idle data bus, response count.
   always @(posedge clk) begin
      if (rst_n) begin
         if (!({LdA, LdB, LdP, clrP, decB} inside {5'b00000, 5'b10000, 5'b01010, 5'b00101}))
            viol <= viol + 1;
         if (!(LdA || LdB) && data_out != '0)
            viol <= viol + 1;
         if (rsp_valid)
            rsp_seen <= rsp_seen + 1;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic set_req(input int idx, input logic [W-1:0] a, input logic [W-1:0] b);
      req_valid[idx]     = 1'b1;
      req_a[idx*W +: W]  = a;
      req_b[idx*W +: W]  = b;
   endtask

   // One full transaction: ack at k=0, LdA at k=1, LdB/clrP at k=2, rsp at k=exp_lat.
   task automatic transact(input string tag, input int idx,
                           input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] exp_da, input logic [W-1:0] exp_db,
                           input logic [W-1:0] exp_p, input int exp_lat);
      int k;
      int ldp;
      bit done;
      @(negedge clk);
      set_req(idx, a, b);
      #1;
      check({tag, ".ack"}, 32'(req_ack), 32'(1 << idx));
      check({tag, ".busy0"}, 32'(busy), 32'd0);
      k = 0; ldp = 0; done = 1'b0;
      while (!done && k < 300) begin
         @(negedge clk);
         if (k == 0) req_valid[idx] = 1'b0;
         #1;
         k++;
         if (k == 1) begin
            check({tag, ".lda"}, 32'({LdA, LdB, clrP, busy}), 32'b1001);
            check({tag, ".data_a"}, 32'(data_out), 32'(exp_da));
         end
         if (k == 2) begin
            check({tag, ".ldb_clrp"}, 32'({LdA, LdB, clrP}), 32'b011);
            check({tag, ".data_b"}, 32'(data_out), 32'(exp_db));
         end
         if (LdP) ldp++;
         if (rsp_valid) done = 1'b1;
      end
      check({tag, ".rsp_seen"}, 32'(done), 32'd1);
      check({tag, ".latency"}, 32'(k), 32'(exp_lat));
      check({tag, ".rsp_data"}, 32'(rsp_data), 32'(exp_p));
      check({tag, ".rsp_id"}, 32'(rsp_id), 32'(idx));
      check({tag, ".ldp_pulses"}, 32'(ldp), 32'(exp_lat - 4));
      @(negedge clk);
      #1;
      check({tag, ".after"}, 32'({rsp_valid, busy}), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int order[5];
      int c;
      int snap;
      logic [W-1:0] prod[NREQ];

      rst_n     = 1'b0;
      req_valid = '0;
      req_a     = '0;
      req_b     = '0;

      // Reset state
      #12;
      check("reset.ctl", 32'({busy, LdA, LdB, LdP, clrP, decB, rsp_valid, req_ack}), 32'd0);
      check("reset.data", 32'({data_out, rsp_data}), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // 1: 17*5, first grant after reset goes to req 0
      transact("t1", 0, 16'd17, 16'd5, 16'd17, 16'd5, 16'd85, 9);
      // 2: B=0 -> product 0 with no iterations
      transact("t2", 1, 16'd9, 16'd0, 16'd9, 16'd0, 16'd0, 4);
      // 4: product wraps mod 2^16
      transact("t4", 2, 16'hFFFF, 16'd3, 16'hFFFF, 16'd3, 16'hFFFD, 7);

      // 6: operand swap
`ifdef MUL_OPSWAP_EN
      transact("t6", 3, 16'd2, 16'd100, 16'd100, 16'd2, 16'd200, 6);
`else
      transact("t6", 3, 16'd2, 16'd100, 16'd2, 16'd100, 16'd200, 104);
`endif

      // 5: reset during RUN abandons the transaction
      @(negedge clk);
      set_req(3, 16'd10, 16'd50);
      #1;
      check("t5.ack", 32'(req_ack), 32'b1000);
      @(negedge clk);
      req_valid = '0;
      repeat (4) @(negedge clk);
      #1;
      check("t5.in_run", 32'({LdP, decB, busy}), 32'b111);
      snap = rsp_seen;
      rst_n = 1'b0;
      #1;
      check("t5.rst_ctl", 32'({busy, LdA, LdB, LdP, clrP, decB, rsp_valid, req_ack}), 32'd0);
      check("t5.rst_data", 32'({data_out, rsp_data}), 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (10) @(negedge clk);
      #1;
      check("t5.no_rsp", 32'(rsp_seen), 32'(snap));
      check("t5.idle", 32'(busy), 32'd0);
      transact("t5b", 2, 16'd7, 16'd6, 16'd7, 16'd6, 16'd42, 10);

      // 3: all four requests held from reset; req 0 re-asserts after its rsp
      @(negedge clk);
      rst_n = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         set_req(i, 16'(i + 2), 16'(i + 1));
         prod[i] = 16'((i + 2) * (i + 1));
      end
      #1;
      check("t3.ack_in_reset", 32'(req_ack), 32'd0);
      order = '{0, 1, 2, 3, 0};
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      for (int n = 0; n < 5; n++) begin
         c = 0;
         while (req_ack == '0 && c < 40) begin
            @(negedge clk);
            #1;
            c++;
         end
         check($sformatf("t3.ack%0d", n), 32'(req_ack), 32'(1 << order[n]));
         @(negedge clk);
         req_valid[order[n]] = 1'b0;
         #1;
         c = 0;
         while (!rsp_valid && c < 40) begin
            @(negedge clk);
            #1;
            c++;
         end
         check($sformatf("t3.rsp_id%0d", n), 32'(rsp_id), 32'(order[n]));
         check($sformatf("t3.rsp_data%0d", n), 32'(rsp_data), 32'(prod[order[n]]));
         if (n == 0) req_valid[0] = 1'b1;
      end
      repeat (3) @(negedge clk);
      #1;
      check("t3.idle", 32'({busy, req_ack}), 32'd0);

      check("protocol.violations", 32'(viol), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
